dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder at the far end of the core's load/store interface.
//  Accepts rd_en/wr_en requests with byte address, write data and funct3 mask.
//  Performs byte/half/word access with sign or zero extension.
//  Inserts LATENCY wait cycles via stall, so cache-miss timing can be emulated
//  before the real cache controller is attached.
// PARAMETERS
//  DEPTH    1024  number of 32-bit words; power of two
//  LATENCY  2     wait cycles per access; 0 = single-cycle, no stall
// PORTS
//  clk       in   1   rising-edge clock
//  reset     in   1   asynchronous, active-high reset
//  addr      in   32  byte address from alu_out
//  wdata     in   32  store data, right-aligned
//  mask      in   3   funct3 of the load/store
//  rd_en     in   1   load request
//  wr_en     in   1   store request
//  rdata     out  32  extended load data; valid only in the completion cycle
//  stall     out  1   core must hold its PC/pipeline while high
//  misalign  out  1   1-cycle pulse: misaligned access, discarded
// BEHAVIOUR
//  Reset:
//  - Async reset: state=IDLE, counter=0, capture regs=0.
//  - Outputs forced to 0 while reset is high: rdata, stall, misalign.
//  - RAM contents are not reset.
//  - Reset mid-access drops the pending access; no write occurs.
//  Request capture:
//  - req = rd_en|wr_en.
//  - In IDLE with req: latch addr, wdata, mask, and is_st=wr_en.
//  - Only the captured values are used; input changes during stall are ignored.
//  - rd_en&wr_en together is treated as a store.
//  FSM IDLE/WAIT/DONE:
//  - LATENCY=0: access completes in the IDLE cycle, using the live inputs.
//  - LATENCY>0, IDLE+req: stall=1, cnt<=LATENCY-1.
//    - If LATENCY=1, go to DONE; otherwise go to WAIT.
//  - WAIT: stall=1, cnt decrements; move to DONE on the cycle cnt==1.
//  - DONE: stall=0 (completion cycle), then return to IDLE.
//    - No new request is accepted in DONE.
//  Access:
//  - Word index = addr[$clog2(DEPTH)+1:2]; upper bits ignored (wraps).
//  - Load rdata is combinational in the completion cycle:
//    - LB  (000): sign-extend the addressed byte.
//    - LH  (001): sign-extend the addressed half.
//    - LW  (010): the full word.
//    - LBU (100): zero-extend the addressed byte.
//    - LHU (101): zero-extend the addressed half.
//    - Other mask codes: rdata=0.
//  - rdata=0 outside the completion cycle and for stores.
//  - Stores commit on the clock edge that ends the completion cycle, using byte enables:
//    - SB (000): 1 lane, set by addr[1:0].
//    - SH (001): lanes 0011 or 1100.
//    - SW (010): all 4 lanes.
//    - Other mask codes: no write.
//  - Writes and reads of the same word in back-to-back accesses see the new data.
//  Misalignment:
//  - Condition: half access with addr[0]=1, or word access with addr[1:0]!=0.
//  - Full latency still elapses.
//  - In the completion cycle: misalign=1, rdata=0, no write.
// STRUCTURE
//  - Package dmem_pkg:
//    - funct3 localparams F3_B/F3_H/F3_W/F3_BU/F3_HU.
//    - typedef enum logic[1:0] {IDLE,WAIT,DONE} dmem_state_t.
//  - Sub-module dmem_lane_ctrl, combinational, taking mask, addr[1:0], wdata and raw word.
//    - Produces byte enables, lane-shifted write data, extended load data and the misalign flag.
//  - Top holds the FSM, counter, capture regs and RAM array.
// TESTING
//  1. LATENCY=2: SW 0xDEADBEEF @0x10, then LW @0x10.
//     -> stall high 2 cycles per access; rdata=0xDEADBEEF in the DONE cycle.
//  2. Word @0x20=0x00000000, then SB 0x80 @0x23, then LB @0x23 and LBU @0x23.
//     -> rdata=0xFFFFFF80 and 0x00000080; word @0x20=0x80000000.
//  3. SH 0x8001 @0x42, then LH @0x42 and LHU @0x42.
//     -> rdata=0xFFFF8001 and 0x00008001; lanes 0-1 unchanged.
//  4. LW @0x11 and SH @0x43.
//     -> misalign pulses once per access; rdata=0; memory unchanged.
//  5. Assert reset during WAIT of a SW @0x8.
//     -> stall=0 immediately; word @0x8 unchanged; next LW completes normally.
//  6. LATENCY=0, DEPTH=1024: SW 0x5 @0x1000, then LW @0x0.
//     -> stall never high; rdata=0x5 (address wrap).

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 access codes and
// the access FSM state type.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_lane_ctrl.sv
// Byte-lane steering for one 32-bit memory word: store byte enables and lane
// replication, load extraction with sign/zero extension, misalignment detect.
module dmem_lane_ctrl
  import dmem_pkg::*;
(
  input  logic [2:0]  mask,
  input  logic [1:0]  byte_off,
  input  logic [31:0] wdata,
  input  logic [31:0] raw_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lane,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic        is_half_s;
  logic        is_word_s;

  assign half_s    = byte_off[1] ? raw_word[31:16] : raw_word[15:0];
  assign is_half_s = (mask == F3_H) || (mask == F3_HU);
  assign is_word_s = (mask == F3_W);
  assign misalign  = (is_half_s && byte_off[0]) || (is_word_s && (byte_off != 2'b00));

  // Select the addressed byte of the raw word
  always_comb begin
    byte_s = 8'd0;
    case (byte_off)
      2'b00:   byte_s = raw_word[7:0];
      2'b01:   byte_s = raw_word[15:8];
      2'b10:   byte_s = raw_word[23:16];
      2'b11:   byte_s = raw_word[31:24];
      default: byte_s = 8'd0;
    endcase
  end

  // Extend the addressed byte/half to 32 bits
  always_comb begin
    load_data = 32'd0;
    case (mask)
      F3_B:    load_data = {{24{byte_s[7]}}, byte_s};
      F3_H:    load_data = {{16{half_s[15]}}, half_s};
      F3_W:    load_data = raw_word;
      F3_BU:   load_data = {24'd0, byte_s};
      F3_HU:   load_data = {16'd0, half_s};
      default: load_data = 32'd0;
    endcase
  end

  // Store data is replicated to every lane; byte enables pick the live ones
  always_comb begin
    byte_en    = 4'b0000;
    wdata_lane = 32'd0;
    case (mask)
      F3_B: begin
        byte_en    = 4'b0001 << byte_off;
        wdata_lane = {4{wdata[7:0]}};
      end
      F3_H: begin
        byte_en    = byte_off[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
      end
      F3_W: begin
        byte_en    = 4'b1111;
        wdata_lane = wdata;
      end
      default: begin
        byte_en    = 4'b0000;
        wdata_lane = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the core's load/store port. Emulates a fixed
// access latency with stall, then completes loads/stores on a word RAM.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  mask,
  input  logic        rd_en,
  input  logic        wr_en,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  dmem_state_t      state_r;
  dmem_state_t      state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             capture_s;

  logic [31:0]      addr_r;
  logic [31:0]      wdata_r;
  logic [2:0]       mask_r;
  logic             is_st_r;

  logic             req_s;
  logic [31:0]      acc_addr_s;
  logic [31:0]      acc_wdata_s;
  logic [2:0]       acc_mask_s;
  logic             acc_st_s;
  logic             done_s;

  logic [IDX_W-1:0] word_idx_s;
  logic [31:0]      raw_word_s;
  logic [3:0]       byte_en_s;
  logic [31:0]      wdata_lane_s;
  logic [31:0]      load_data_s;
  logic             mis_s;
  logic             we_s;
  logic             unused_addr_s;

  logic [31:0]      mem_r [DEPTH];

  assign req_s = rd_en | wr_en;

  // With zero latency the access runs straight off the live request
  always_comb begin
    if (LATENCY == 0) begin
      acc_addr_s  = addr;
      acc_wdata_s = wdata;
      acc_mask_s  = mask;
      acc_st_s    = wr_en;
      done_s      = req_s;
    end else begin
      acc_addr_s  = addr_r;
      acc_wdata_s = wdata_r;
      acc_mask_s  = mask_r;
      acc_st_s    = is_st_r;
      done_s      = (state_r == DONE);
    end
  end

  assign word_idx_s    = acc_addr_s[IDX_W+1:2];
  assign unused_addr_s = ^acc_addr_s[31:IDX_W+2];
  assign raw_word_s    = mem_r[word_idx_s];

  dmem_lane_ctrl u_lane_ctrl (
    .mask       (acc_mask_s),
    .byte_off   (acc_addr_s[1:0]),
    .wdata      (acc_wdata_s),
    .raw_word   (raw_word_s),
    .byte_en    (byte_en_s),
    .wdata_lane (wdata_lane_s),
    .load_data  (load_data_s),
    .misalign   (mis_s)
  );

  // Next-state and wait-counter logic
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    capture_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s && (LATENCY != 0)) begin
          capture_s   = 1'b1;
          cnt_nxt_s   = CNT_W'(LATENCY - 1);
          state_nxt_s = (LATENCY == 1) ? DONE : WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        cnt_nxt_s = cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(1)) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, counter and request capture registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
      mask_r  <= 3'd0;
      is_st_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (capture_s) begin
        addr_r  <= addr;
        wdata_r <= wdata;
        mask_r  <= mask;
        is_st_r <= wr_en;
      end
    end
  end

  assign stall    = ~reset & (((state_r == IDLE) && req_s && (LATENCY != 0)) || (state_r == WAIT));
  assign misalign = ~reset & done_s & mis_s;
  assign rdata    = (~reset & done_s & ~acc_st_s & ~mis_s) ? load_data_s : 32'd0;
  assign we_s     = ~reset & done_s & acc_st_s & ~mis_s;

  // Byte-lane RAM write on the edge that ends the completion cycle
  always_ff @(posedge clk) begin
    if (we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en_s[i]) begin
          mem_r[word_idx_s][8*i +: 8] <= wdata_lane_s[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: a LATENCY=2 instance and a LATENCY=0 instance, driven by
// a directed vector table, a reset-abort sequence and randomized accesses.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic [31:0] a_addr = 32'd0, a_wdata = 32'd0, a_rdata;
  logic [2:0]  a_mask = 3'd0;
  logic        a_rd = 1'b0, a_wr = 1'b0, a_stall, a_mis;

  logic [31:0] b_addr = 32'd0, b_wdata = 32'd0, b_rdata;
  logic [2:0]  b_mask = 3'd0;
  logic        b_rd = 1'b0, b_wr = 1'b0, b_stall, b_mis;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [2][32];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(1024), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .addr(a_addr), .wdata(a_wdata), .mask(a_mask),
    .rd_en(a_rd), .wr_en(a_wr), .rdata(a_rdata), .stall(a_stall), .misalign(a_mis)
  );

  dmem_responder #(.DEPTH(1024), .LATENCY(0)) u_l0 (
    .clk(clk), .reset(reset), .addr(b_addr), .wdata(b_wdata), .mask(b_mask),
    .rd_en(b_rd), .wr_en(b_wr), .rdata(b_rdata), .stall(b_stall), .misalign(b_mis)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  mask;
    logic [31:0] exp_rdata;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] m);
    if (sel == 0) begin
      a_rd = rd; a_wr = wr; a_addr = a; a_wdata = wd; a_mask = m;
    end else begin
      b_rd = rd; b_wr = wr; b_addr = a; b_wdata = wd; b_mask = m;
    end
  endtask

  function automatic logic obs_stall(input int sel);
    return (sel == 0) ? a_stall : b_stall;
  endfunction
  function automatic logic obs_mis(input int sel);
    return (sel == 0) ? a_mis : b_mis;
  endfunction
  function automatic logic [31:0] obs_rdata(input int sel);
    return (sel == 0) ? a_rdata : b_rdata;
  endfunction

  // Reference model: access rules written as plain arithmetic
  function automatic logic ref_mis(input logic [31:0] a, input logic [2:0] m);
    return ((m == 3'd1 || m == 3'd5) && a[0]) || (m == 3'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a, input logic [2:0] m);
    int unsigned b, h;
    b = (w >> (8 * int'(a[1:0]))) & 32'hFF;
    h = (w >> (16 * int'(a[1]))) & 32'hFFFF;
    case (m)
      3'd0:    return (b >= 128) ? b - 256 : b;
      3'd1:    return (h >= 32768) ? h - 65536 : h;
      3'd2:    return w;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [31:0] a,
                                            input logic [31:0] wd, input logic [2:0] m);
    int sh;
    case (m)
      3'd0: begin
        sh = 8 * int'(a[1:0]);
        return (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
      end
      3'd1: begin
        sh = 16 * int'(a[1]);
        return (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
      end
      3'd2:    return wd;
      default: return w;
    endcase
  endfunction

  task automatic model(input int sel, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] m, output logic [31:0] exp_rd, output logic exp_mis);
    logic [4:0] idx;
    idx     = a[6:2];
    exp_mis = ref_mis(a, m);
    exp_rd  = 32'd0;
    if (!exp_mis) begin
      if (wr) ref_mem[sel][idx] = ref_store(ref_mem[sel][idx], a, wd, m);
      else    exp_rd = ref_load(ref_mem[sel][idx], a, m);
    end
  endtask

  // One access: request held until the completion cycle, inputs scrambled while waiting
  task automatic acc(input int sel, input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] wd, input logic [2:0] m,
                     output logic [31:0] rd_o, output int stalls, output int mis_o, output int leak);
    logic        done;
    logic [31:0] r;
    @(posedge clk); #1;
    drive(sel, rd, wr, a, wd, m);
    stalls = 0; mis_o = 0; leak = 0; done = 1'b0; rd_o = 32'd0;
    for (int i = 0; i < 16 && !done; i++) begin
      @(negedge clk);
      if (obs_mis(sel)) mis_o++;
      if (obs_stall(sel)) begin
        stalls++;
        if (obs_rdata(sel) != 32'd0) leak++;
        if (i >= 1) begin
          r = $urandom();
          drive(sel, rd, wr, r, $urandom(), r[2:0]);
        end
      end else begin
        rd_o = obs_rdata(sel);
        done = 1'b1;
      end
    end
    chk("completion_timeout", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
  endtask

  task automatic run(input int sel, input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] wd, input logic [2:0] m, input string nm,
                     input logic use_tbl, input logic [31:0] t_rd, input logic t_mis);
    logic [31:0] got, exp_rd;
    logic        exp_mis;
    int          stalls, mis_cnt, leak;
    acc(sel, rd, wr, a, wd, m, got, stalls, mis_cnt, leak);
    model(sel, wr, a, wd, m, exp_rd, exp_mis);
    if (use_tbl) begin
      exp_rd  = t_rd;
      exp_mis = t_mis;
    end
    chk({nm, "_rdata"}, got, exp_rd);
    chk({nm, "_misalign"}, mis_cnt, exp_mis ? 32'd1 : 32'd0);
    chk({nm, "_stall_cycles"}, stalls, (sel == 0) ? 32'd2 : 32'd0);
    chk({nm, "_rdata_during_stall"}, leak, 32'd0);
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                              input logic [2:0] m, input logic [31:0] er, input logic em);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd; v.mask = m; v.exp_rdata = er; v.exp_mis = em;
    return v;
  endfunction

  initial begin
    logic [31:0] r;
    logic [4:0]  idx;
    logic [2:0]  m;
    int          kind;

    // Reset state: outputs held at zero even with a live request
    drive(0, 1'b1, 1'b0, 32'h10, 32'd0, 3'd2);
    drive(1, 1'b1, 1'b1, 32'h11, 32'd0, 3'd2);
    #12;
    chk("reset_stall_l2", {31'd0, a_stall}, 32'd0);
    chk("reset_rdata_l2", a_rdata, 32'd0);
    chk("reset_misalign_l0", {31'd0, b_mis}, 32'd0);
    chk("reset_rdata_l0", b_rdata, 32'd0);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    @(negedge clk);
    reset = 1'b0;

    // Fill the 32-word test window of both instances
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 32; i++) begin
        r   = $urandom();
        idx = i[4:0];
        run(s, 1'b0, 1'b1, {r[31:12], 5'd0, idx, 2'b00}, $urandom(), 3'd2, "init", 1'b0, 32'd0, 1'b0);
      end
    end

    vecs.push_back(mk(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd2, 32'h0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 32'h10, 32'h0,        3'd2, 32'hDEADBEEF, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 32'h20, 32'h0,        3'd2, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 32'h23, 32'h80,       3'd0, 32'h0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 32'h23, 32'h0,        3'd0, 32'hFFFFFF80, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 32'h23, 32'h0,        3'd4, 32'h00000080, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 32'h20, 32'h0,        3'd2, 32'h80000000, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 32'h40, 32'h12345678, 3'd2, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 32'h42, 32'hABCD8001, 3'd1, 32'h0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 32'h42, 32'h0,        3'd1, 32'hFFFF8001, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 32'h42, 32'h0,        3'd5, 32'h00008001, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 32'h40, 32'h0,        3'd2, 32'h80015678, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 32'h11, 32'h0,        3'd2, 32'h0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 32'h43, 32'hFFFF,     3'd1, 32'h0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 32'h40, 32'h0,        3'd2, 32'h80015678, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 32'h10, 32'h0,        3'd2, 32'hDEADBEEF, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 32'h10, 32'h0,        3'd3, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 32'h40, 32'hFFFFFFFF, 3'd6, 32'h0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 32'h41, 32'h0,        3'd0, 32'h00000056, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 32'h42, 32'h0,        3'd4, 32'h00000001, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 32'h43, 32'h0,        3'd0, 32'hFFFFFF80, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 32'h40, 32'h0,        3'd1, 32'h00005678, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 32'h44, 32'h0BADF00D, 3'd2, 32'h0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 32'h44, 32'h0,        3'd2, 32'h0BADF00D, 1'b0));

    foreach (vecs[i]) begin
      run(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].mask,
          $sformatf("vec%0d", i), 1'b1, vecs[i].exp_rdata, vecs[i].exp_mis);
    end

    // Reset during the wait phase of a store: the write must be dropped
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 32'h8, 32'h11111111, 3'd2);
    @(negedge clk);
    chk("abort_stall_idle", {31'd0, a_stall}, 32'd1);
    @(posedge clk); #1;
    chk("abort_stall_wait", {31'd0, a_stall}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_stall_reset", {31'd0, a_stall}, 32'd0);
    chk("abort_rdata_reset", a_rdata, 32'd0);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    @(negedge clk);
    reset = 1'b0;
    run(0, 1'b1, 1'b0, 32'h8, 32'd0, 3'd2, "abort_reload", 1'b0, 32'd0, 1'b0);

    // Zero-latency instance: upper address bits wrap onto word 0
    run(1, 1'b0, 1'b1, 32'h1000, 32'h5, 3'd2, "l0_sw_wrap", 1'b1, 32'h0, 1'b0);
    run(1, 1'b1, 1'b0, 32'h0, 32'h0, 3'd2, "l0_lw_wrap", 1'b1, 32'h5, 1'b0);

    // Randomized accesses against the model, both instances
    for (int s = 0; s < 2; s++) begin
      for (int n = 0; n < 150; n++) begin
        r    = $urandom();
        idx  = 5'($urandom_range(0, 31));
        m    = 3'($urandom_range(0, 7));
        kind = $urandom_range(0, 2);
        run(s, kind != 1, kind != 0, {r[31:12], 5'd0, idx, r[1:0]}, $urandom(), m,
            $sformatf("rand%0d_%0d", s, n), 1'b0, 32'd0, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
